adc_sample_fifo: RTL and testbench
==================================

# adc_sample_fifo

Single-clock sample FIFO controller that sits directly upstream of the simple dual-port RAM (`simple_dpram_sclk`, bypass enabled) in the SAR ADC data path. It accepts conversion results from the ADC sequencer and generates the RAM write and read port controls. It presents a show-ahead valid/ready stream to the Wishbone/DMA consumer, using the RAM's registered read data as its output stage. It also counts samples dropped when the buffer is full.

## Interface
Parameters:
- `ADDR_WIDTH`, 4: RAM address width. RAM holds at most 2^ADDR_WIDTH-1 words; total capacity is 2^ADDR_WIDTH.
- `DATA_WIDTH`, 12: sample width.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst` input 1: synchronous active-high reset.
- `flush` input 1: synchronous clear of FIFO contents. The drop counter and overflow flag are not cleared by `flush`.
- `s_data` input DATA_WIDTH: sample from the ADC sequencer.
- `s_valid` input 1: sample present. The source cannot stall.
- `s_ready` output 1: FIFO can accept a sample this cycle.
- `m_data` output DATA_WIDTH: head sample, driven from `ram_dout`.
- `m_valid` output 1: head sample valid.
- `m_ready` input 1: consumer accepts head.
- `level` output ADDR_WIDTH+1: words held, counting the RAM plus the output stage.
- `overflow` output 1: sticky, set when a sample is dropped.
- `ovf_clr` input 1: clears `overflow` and `drop_cnt`.
- `drop_cnt` output 8: dropped-sample count, saturates at 255.
- `ram_waddr`, `ram_raddr` outputs ADDR_WIDTH: RAM write and read addresses.
- `ram_we`, `ram_re` outputs 1: RAM write and read enables.
- `ram_din` output DATA_WIDTH: RAM write data.
- `ram_dout` input DATA_WIDTH: RAM read data, valid one cycle after `ram_re`, held while `ram_re`=0.

## Operation
- State: `wptr`, `rptr` (ADDR_WIDTH, wrapping modulo 2^ADDR_WIDTH), `ram_cnt` (ADDR_WIDTH bits, 0..2^ADDR_WIDTH-1), `m_valid` flag.
- `s_ready` = !rst && (`ram_cnt` != 2^ADDR_WIDTH-1).
- Push:
  - Condition: `s_valid` && `s_ready` && !`flush`.
  - Effect: `ram_we`=1, `ram_waddr`=`wptr`, `ram_din`=`s_data`; `wptr`++.
- Drop:
  - Condition: `s_valid` && !`s_ready` && !`rst` && !`flush`.
  - Effect: `overflow`<=1; `drop_cnt`++, saturating at 255.
  - If `ovf_clr` occurs in the same cycle as a drop, the clear wins.
- Fetch:
  - Condition: `ram_cnt`>0 && (!`m_valid` || `m_ready`) && !`flush`.
  - Effect: `ram_re`=1, `ram_raddr`=`rptr`; `rptr`++; `m_valid`<=1.
- Pop without fetch: `m_valid` && `m_ready` && no fetch → `m_valid`<=0.
- Count update: `ram_cnt` <= `ram_cnt` + push − fetch. Push and fetch in the same cycle leave `ram_cnt` unchanged.
- Because the RAM capacity is 2^ADDR_WIDTH-1, a fetch never addresses `wptr` while `ram_cnt`>0. The RAM bypass path is therefore never exercised with stale-vs-new ambiguity.
- `level` = `ram_cnt` + `m_valid`.
- `flush` or `rst`:
  - Clears `wptr`, `rptr`, `ram_cnt`, `m_valid`.
  - Forces `ram_we`=`ram_re`=0.
  - `rst` additionally clears `overflow` and `drop_cnt`.
- Samples are delivered in strict arrival order across pointer wrap.

## Timing
- Reset values (the cycle after `rst` is high):
  - `m_valid`=0, `level`=0, `overflow`=0, `drop_cnt`=0, `s_ready`=1.
  - `s_ready`=0 while `rst` is high.
- `ram_we`, `ram_re`, `ram_waddr`, `ram_raddr`, `ram_din` are combinational from registered state and inputs, and are sampled by the RAM on the same edge.
- Latency from an accepted push in cycle t to `m_valid`=1 with an empty FIFO: 2 cycles. The fetch is issued in cycle t+1, so `m_valid` and `m_data` appear in t+2.
- Back-to-back streaming with `m_ready` held at 1: one word per cycle sustained.
- `m_data` is stable while `m_valid` && !`m_ready`.
- At full, a pop in cycle t raises `s_ready` in t+1 (`ram_cnt` decrements after the fetch). A push in t with `s_ready`=0 is a drop.
- Reset or flush mid-stream: any fetched-but-unpopped word is discarded, and `m_valid`=0 the next cycle.

## Test plan
- Reset: hold `rst` 2 cycles with `s_valid`=1 → after release, `m_valid`=0, `level`=0, `s_ready`=1, `drop_cnt`=0, no RAM write occurred.
- Latency: with ADDR_WIDTH=3 and the FIFO empty, push 0x5A5 in cycle t → `m_valid`=1 and `m_data`=0x5A5 in t+2; pop → `level`=0.
- Full/overflow: `m_ready`=0, push 10 samples 1..10 on consecutive cycles → `s_ready` drops after 8 accepted, `level`=8, `overflow`=1, `drop_cnt`=2. Then draining yields 1..8.
- Wrap and throughput: `m_ready`=1, stream 40 incrementing samples → output order 0..39 with no gaps after the 2-cycle startup, and `drop_cnt`=0.
- Random backpressure: toggle `m_ready` pseudo-randomly while pushing at 50% for 500 samples → scoreboard matches, `m_data` stable during stall, `level` never exceeds 8.
- Flush mid-operation: with `level`=5, assert `flush` 1 cycle → next cycle `level`=0 and `m_valid`=0. `overflow` and `drop_cnt` are unchanged; `ovf_clr` then zeroes them.

Source files
------------

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: show-ahead sample FIFO controller for the ADC data path.
// It drives an external simple dual-port RAM that has a registered read port.
// That RAM read register is the FIFO output stage.
// At most 2^ADDR_WIDTH-1 words sit in RAM, so a fetch never reads the slot being written.
// Samples arriving while the RAM is full are dropped and counted; the count is sticky.
module adc_sample_fifo #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic [7:0]            drop_cnt,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    // RAM occupancy ceiling: one slot is always left free.
    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH-1:0] ram_cnt_q, ram_cnt_d;
    logic                  m_valid_q, m_valid_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            drop_cnt_q, drop_cnt_d;

    logic push;
    logic drop;
    logic fetch;

    // Handshake decode: accept, drop, and refill of the output stage.
    always_comb begin
        s_ready = !rst && (ram_cnt_q != CNT_MAX);
        push    = s_valid && s_ready && !flush;
        drop    = s_valid && !s_ready && !rst && !flush;
        // Refill the output stage whenever it is empty or being popped.
        fetch   = (ram_cnt_q != '0) && (!m_valid_q || m_ready) && !flush && !rst;
    end

    // Next-state computation for pointers, occupancy, head-valid and drop statistics.
    always_comb begin
        wptr_d     = wptr_q + ADDR_WIDTH'(push);
        rptr_d     = rptr_q + ADDR_WIDTH'(fetch);
        ram_cnt_d  = ram_cnt_q;
        m_valid_d  = m_valid_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        case ({push, fetch})
            2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
            2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
            default: ram_cnt_d = ram_cnt_q;
        endcase

        if (fetch) begin
            m_valid_d = 1'b1;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        // A fetched-but-unpopped word is discarded by flush.
        if (flush) begin
            wptr_d    = '0;
            rptr_d    = '0;
            ram_cnt_d = '0;
            m_valid_d = 1'b0;
        end

        // Clear has priority over a simultaneous drop.
        if (ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            m_valid_q  <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_cnt_q  <= ram_cnt_d;
            m_valid_q  <= m_valid_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // RAM port controls and stream outputs.
    always_comb begin
        ram_we    = push;
        ram_waddr = wptr_q;
        ram_din   = s_data;
        ram_re    = fetch;
        ram_raddr = rptr_q;
        m_data    = ram_dout;
        m_valid   = m_valid_q;
        level     = {1'b0, ram_cnt_q} + (ADDR_WIDTH + 1)'(m_valid_q);
        overflow  = overflow_q;
        drop_cnt  = drop_cnt_q;
    end

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed testbench for adc_sample_fifo (ADDR_WIDTH=3, 8-word capacity).
// It includes a behavioural model of the bypass-enabled registered-read RAM.
module tb_adc_sample_fifo;

    localparam int AW = 3;
    localparam int DW = 12;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [AW:0]   level;
    logic          overflow;
    logic          ovf_clr;
    logic [7:0]    drop_cnt;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic          ram_we;
    logic          ram_re;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int total = 0;
    int bad   = 0;

    adc_sample_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .level(level), .overflow(overflow), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt),
        .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .ram_we(ram_we), .ram_re(ram_re),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: registered read, write-first bypass, dout held while re=0.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int wr_count = 0;
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_din;
            wr_count <= wr_count + 1;
        end
        if (ram_re) begin
            ram_dout <= (ram_we && ram_waddr == ram_raddr) ? ram_din : mem[ram_raddr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;
        int sent;
        int cyc;
        int exp_drops;
        logic stall_prev;
        logic [DW-1:0] held;
        logic [DW-1:0] exp_word;
        logic [DW-1:0] sb[$];

        // ---- reset held 2 cycles with s_valid high ----
        rst = 1'b1; flush = 1'b0; s_valid = 1'b1; s_data = 12'h123;
        m_ready = 1'b0; ovf_clr = 1'b0;
        #1;
        check("rst_s_ready_low", s_ready, 0);
        check("rst_no_we", ram_we, 0);
        tick();
        tick();
        rst = 1'b0; s_valid = 1'b0;
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_level", level, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_overflow", overflow, 0);
        check("rst_no_writes", wr_count, 0);

        // ---- latency: push 0x5A5 into an empty FIFO ----
        s_valid = 1'b1; s_data = 12'h5A5;
        #1;
        check("lat_we", ram_we, 1);
        check("lat_waddr", ram_waddr, 0);
        check("lat_din", ram_din, 12'h5A5);
        tick();
        s_valid = 1'b0;
        #1;
        check("lat_t1_m_valid", m_valid, 0);
        check("lat_t1_re", ram_re, 1);
        check("lat_t1_raddr", ram_raddr, 0);
        tick();
        check("lat_t2_m_valid", m_valid, 1);
        check("lat_t2_m_data", m_data, 12'h5A5);
        check("lat_t2_level", level, 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        #1;
        check("lat_pop_level", level, 0);
        check("lat_pop_m_valid", m_valid, 0);

        // ---- full / overflow: 10 pushes with m_ready low ----
        acc = 0;
        for (int i = 1; i <= 10; i++) begin
            s_valid = 1'b1; s_data = DW'(i);
            #1;
            if (s_ready) acc++;
            if (i == 9) check("full_s_ready_9th", s_ready, 0);
            tick();
        end
        s_valid = 1'b0;
        #1;
        check("full_accepted", acc, 8);
        check("full_level", level, 8);
        check("full_overflow", overflow, 1);
        check("full_drop_cnt", drop_cnt, 2);
        check("full_s_ready", s_ready, 0);

        // drop and clear in the same cycle: clear wins
        s_valid = 1'b1; s_data = 12'd11; ovf_clr = 1'b1;
        tick();
        s_valid = 1'b0; ovf_clr = 1'b0;
        #1;
        check("clr_wins_overflow", overflow, 0);
        check("clr_wins_drop_cnt", drop_cnt, 0);
        s_valid = 1'b1; s_data = 12'd12;
        tick();
        s_valid = 1'b0;
        #1;
        check("redrop_overflow", overflow, 1);
        check("redrop_drop_cnt", drop_cnt, 1);

        // drain: expect 1..8 in order
        m_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            n = 0;
            while (!m_valid && n < 10) begin
                tick();
                n++;
            end
            check("drain_m_valid", m_valid, 1);
            check("drain_m_data", m_data, k);
            tick();
            if (k == 1) check("full_pop_s_ready", s_ready, 1);
        end
        m_ready = 1'b0;
        #1;
        check("drain_level", level, 0);

        // ---- flush with level=5 ----
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = DW'(12'h100 + i);
            tick();
        end
        s_valid = 1'b0;
        tick();
        check("pre_flush_level", level, 5);
        flush = 1'b1; s_valid = 1'b1; s_data = 12'hFFF; m_ready = 1'b1;
        #1;
        check("flush_no_we", ram_we, 0);
        check("flush_no_re", ram_re, 0);
        tick();
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        #1;
        check("flush_level", level, 0);
        check("flush_m_valid", m_valid, 0);
        check("flush_keeps_overflow", overflow, 1);
        check("flush_keeps_drop_cnt", drop_cnt, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr_overflow", overflow, 0);
        check("ovf_clr_drop_cnt", drop_cnt, 0);

        // ---- wrap and throughput: 40 samples, m_ready held high ----
        m_ready = 1'b1;
        for (int c = 0; c < 44; c++) begin
            s_valid = (c < 40);
            s_data  = DW'(c);
            #1;
            if (c >= 2 && c < 42) begin
                check("stream_m_valid", m_valid, 1);
                check("stream_m_data", m_data, c - 2);
            end
            tick();
        end
        s_valid = 1'b0;
        #1;
        check("stream_level", level, 0);
        check("stream_drop_cnt", drop_cnt, 0);

        // ---- random backpressure, 50% push rate ----
        sent = 0; cyc = 0; exp_drops = 0; stall_prev = 1'b0; held = '0;
        while (sent < 500 && cyc < 5000) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = DW'($urandom_range(0, 4095));
            m_ready = 1'($urandom_range(0, 1));
            #1;
            if (stall_prev) begin
                check("stall_m_valid", m_valid, 1);
                check("stall_m_data", m_data, held);
            end
            check("level_max", (level <= 8), 1);
            if (m_valid && m_ready) begin
                exp_word = (sb.size() > 0) ? sb.pop_front() : 'x;
                check("rand_pop_data", m_data, exp_word);
            end
            if (s_valid) begin
                if (s_ready) begin
                    sb.push_back(s_data);
                    sent++;
                end else begin
                    exp_drops++;
                end
            end
            stall_prev = m_valid && !m_ready;
            held = m_data;
            cyc++;
            tick();
        end
        check("rand_sent", sent, 500);
        s_valid = 1'b0; m_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            #1;
            if (m_valid) begin
                exp_word = sb.pop_front();
                check("rand_drain_data", m_data, exp_word);
            end
            tick();
            n++;
        end
        #1;
        check("rand_sb_empty", sb.size(), 0);
        check("rand_level", level, 0);
        check("rand_drop_cnt", drop_cnt, (exp_drops > 255) ? 255 : exp_drops);
        check("rand_overflow", overflow, (exp_drops > 0) ? 1 : 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
